// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction format, opcode constants and issuer FSM states
package cpu_pkg;
  localparam int INSTR_W = 19;
  localparam int OP_W    = 3;
  localparam int DATA_W  = 8;
  localparam int OP_LSB  = 16;
  localparam int A_LSB   = 8;
  localparam int B_LSB   = 0;
  typedef enum logic [OP_W-1:0] {
    OP_HALT = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_NOT  = 3'b101,
    OP_INC  = 3'b110,
    OP_DEC  = 3'b111
  } opcode_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  function automatic logic [OP_W-1:0] f_op(input logic [INSTR_W-1:0] i);
    return i[OP_LSB +: OP_W];
  endfunction
  function automatic logic [DATA_W-1:0] f_a(input logic [INSTR_W-1:0] i);
    return i[A_LSB +: DATA_W];
  endfunction
  function automatic logic [DATA_W-1:0] f_b(input logic [INSTR_W-1:0] i);
    return i[B_LSB +: DATA_W];
  endfunction
endpackage

// File: rtl/issuer_buf.sv
// issuer_buf: register-array buffer with one synchronous write port and one combinational read port
module issuer_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instr_issuer.sv
// instr_issuer: buffers a program, issues it one instruction at a time and captures the results
module instr_issuer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  input  logic [INSTR_W-1:0]       load_instr,
  output logic                     load_ready,
  input  logic                     clr,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [OP_W-1:0]          opcode,
  output logic [DATA_W-1:0]        operand_a,
  output logic [DATA_W-1:0]        operand_b,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  input  logic [DATA_W-1:0]        result_in,
  input  logic                     result_valid,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   results
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  state_t             r_state, w_state_nxt;
  logic [AW:0]        r_count, r_index, r_results;
  logic [AW:0]        w_count_nxt, w_index_nxt, w_results_nxt;
  logic [INSTR_W-1:0] w_instr;
  logic               w_open, w_active, w_halt, w_load, w_res_we;
  assign w_open      = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_active    = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_halt      = (r_state == S_ISSUE) && (f_op(w_instr) == OP_HALT);
  assign load_ready  = w_open && (r_count < FULL);
  assign w_load      = load_valid && load_ready && !clr;
  assign busy        = w_active;
  assign done        = r_state == S_DONE;
  assign issue_valid = (r_state == S_ISSUE) && !w_halt;
  // Fields come straight from the entry at the program index, which only moves on a result
  assign opcode      = w_active ? f_op(w_instr) : '0;
  assign operand_a   = w_active ? f_a(w_instr) : '0;
  assign operand_b   = w_active ? f_b(w_instr) : '0;
  assign count       = r_count;
  assign results     = r_results;
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_index_nxt   = r_index;
    w_results_nxt = r_results;
    w_res_we      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (clr) begin
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_count_nxt = w_load ? r_count + 1'b1 : r_count;
          if (start) begin
            w_index_nxt   = '0;
            w_results_nxt = '0;
            w_state_nxt   = (w_count_nxt == '0) ? S_DONE : S_ISSUE;
          end
        end
      end
      S_ISSUE: w_state_nxt = w_halt ? S_DONE : (issue_ready ? S_WAIT : S_ISSUE);
      S_WAIT: begin
        if (result_valid) begin
          w_res_we      = 1'b1;
          w_results_nxt = r_results + 1'b1;
          w_index_nxt   = r_index + 1'b1;
          w_state_nxt   = (r_index == r_count - 1'b1) ? S_DONE : S_ISSUE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_index   <= '0;
      r_results <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_index   <= w_index_nxt;
      r_results <= w_results_nxt;
    end
  issuer_buf #(.DEPTH(DEPTH), .WIDTH(INSTR_W)) u_prog (
    .clk     (clk),
    .i_we    (w_load),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata (load_instr),
    .i_raddr (r_index[AW-1:0]),
    .o_rdata (w_instr)
  );
  issuer_buf #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_res (
    .clk     (clk),
    .i_we    (w_res_we),
    .i_waddr (r_index[AW-1:0]),
    .i_wdata (result_in),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );
endmodule

// File: tb/tb_instr_issuer.sv
// tb_instr_issuer: table vectors, directed corner sequences and random programs against a program-level model
module tb_instr_issuer;
  localparam int DEPTH = 8;
  logic        clk, rst_n, load_valid, clr, start, issue_ready, result_valid;
  logic [18:0] load_instr;
  logic [7:0]  result_in;
  logic [2:0]  rd_addr;
  logic        load_ready, busy, done, issue_valid;
  logic [2:0]  opcode;
  logic [7:0]  operand_a, operand_b, rd_data;
  logic [3:0]  count, results;
  int          n_chk, n_fail;
  logic [18:0] prog_q[$];
  logic [18:0] iss_q[$];
  typedef struct {
    logic [18:0] instr;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl [7];

  instr_issuer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_instr(load_instr),
    .load_ready(load_ready), .clr(clr), .start(start), .busy(busy), .done(done),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .result_in(result_in),
    .result_valid(result_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .results(results)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return ~a;
      3'd6: return a + 8'd1;
      3'd7: return a - 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    foreach (prog_q[i]) begin
      load_valid = 1'b1;
      load_instr = prog_q[i];
      tick();
    end
    load_valid = 1'b0;
  endtask

  // Responder: random handshake/result latency, with garbage result_valid pulses outside WAIT
  task automatic run_prog(input bit do_start);
    int         cyc;
    bit         pend;
    logic [2:0] po;
    logic [7:0] pa, pb;
    cyc  = 0;
    pend = 0;
    po   = '0;
    pa   = '0;
    pb   = '0;
    iss_q.delete();
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    while (!done && cyc < 300) begin
      issue_ready  = 1'b0;
      result_valid = 1'b0;
      result_in    = 8'hEE;
      if (issue_valid) begin
        result_valid = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) != 0) begin
          issue_ready = 1'b1;
          iss_q.push_back({opcode, operand_a, operand_b});
          po   = opcode;
          pa   = operand_a;
          pb   = operand_b;
          pend = 1;
        end
      end else if (pend && $urandom_range(0, 2) != 0) begin
        result_valid = 1'b1;
        result_in    = alu(po, pa, pb);
        pend         = 0;
      end
      tick();
      cyc++;
    end
    issue_ready  = 1'b0;
    result_valid = 1'b0;
    chk("run completes", done, 1);
  endtask

  // Expected run: every word before the first HALT is issued in order and yields alu(word)
  task automatic verify(input string tag);
    int n;
    n = 0;
    while (n < prog_q.size() && prog_q[n][18:16] != 3'd0) n++;
    chk({tag, " done"}, done, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " results"}, results, n);
    chk({tag, " issued"}, iss_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < iss_q.size()) chk({tag, " issue"}, iss_q[i], prog_q[i]);
      rd_addr = 3'(i);
      #1;
      chk({tag, " rd_data"}, rd_data, alu(prog_q[i][18:16], prog_q[i][15:8], prog_q[i][7:0]));
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_instr = '0;
    clr = 1'b0;
    start = 1'b0;
    issue_ready = 1'b0;
    result_valid = 1'b0;
    result_in = '0;
    rd_addr = '0;
    for (int i = 0; i < 7; i++) tbl[i].instr = {3'(i + 1), 8'h23, 8'h14};
    tbl[0].exp = 8'h37;
    tbl[1].exp = 8'h0F;
    tbl[2].exp = 8'h00;
    tbl[3].exp = 8'h37;
    tbl[4].exp = 8'hDC;
    tbl[5].exp = 8'h24;
    tbl[6].exp = 8'h22;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset issue_valid", issue_valid, 0);
    chk("reset count", count, 0);
    chk("reset results", results, 0);
    chk("reset load_ready", load_ready, 1);
    chk("reset fields", {opcode, operand_a, operand_b}, 0);

    // Seven-opcode program against literal results
    prog_q.delete();
    foreach (tbl[i]) prog_q.push_back(tbl[i].instr);
    load_prog();
    chk("tbl count", count, 7);
    run_prog(1);
    chk("tbl results", results, 7);
    chk("tbl done", done, 1);
    for (int i = 0; i < 7; i++) begin
      chk("tbl issue", (i < iss_q.size()) ? iss_q[i] : 19'h7FFFF, tbl[i].instr);
      rd_addr = 3'(i);
      #1;
      chk("tbl rd_data", rd_data, tbl[i].exp);
    end

    // Stall in ISSUE, ignored clr/start, same-cycle handshake+result
    prog_q = '{{3'd1, 8'h23, 8'h14}, {3'd2, 8'h23, 8'h14}};
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall issue_valid", issue_valid, 1);
      chk("stall fields", {opcode, operand_a, operand_b}, prog_q[0]);
      clr = (k == 1);
      start = (k == 2);
      tick();
      clr = 1'b0;
      start = 1'b0;
    end
    chk("stall count kept", count, 2);
    chk("stall busy", busy, 1);
    issue_ready = 1'b1;
    result_valid = 1'b1;
    result_in = 8'hEE;
    tick();
    issue_ready = 1'b0;
    result_valid = 1'b0;
    chk("wait issue_valid", issue_valid, 0);
    chk("wait busy", busy, 1);
    chk("wait fields", {opcode, operand_a, operand_b}, prog_q[0]);
    chk("same-cycle result ignored", results, 0);
    tick();
    tick();
    chk("wait hold results", results, 0);
    result_valid = 1'b1;
    result_in = 8'h37;
    tick();
    result_valid = 1'b0;
    chk("after result results", results, 1);
    chk("after result next fields", {issue_valid, opcode, operand_a, operand_b}, {1'b1, prog_q[1]});
    run_prog(0);
    chk("stall results", results, 2);
    rd_addr = 3'd0;
    #1;
    chk("stall rd0", rd_data, 8'h37);
    rd_addr = 3'd1;
    #1;
    chk("stall rd1", rd_data, 8'h0F);

    // Overfill: ninth word refused
    clr = 1'b1;
    tick();
    clr = 1'b0;
    prog_q.delete();
    for (int i = 0; i < 9; i++) begin
      load_valid = 1'b1;
      load_instr = {3'd1, 8'(i), 8'h01};
      if (i < 8) prog_q.push_back(load_instr);
      chk("fill load_ready", load_ready, (i < 8) ? 1 : 0);
      tick();
    end
    load_valid = 1'b0;
    chk("fill count", count, 8);
    run_prog(1);
    verify("full");

    // HALT mid-program
    prog_q = '{{3'd1, 8'h23, 8'h14}, {3'd0, 8'h23, 8'h14}, {3'd2, 8'h23, 8'h14}};
    load_prog();
    run_prog(1);
    verify("halt");
    rd_addr = 3'd0;
    #1;
    chk("halt rd0", rd_data, 8'h37);

    // clr beats a same-cycle load, then start on an empty program
    clr = 1'b1;
    load_valid = 1'b1;
    load_instr = {3'd1, 8'h11, 8'h22};
    tick();
    clr = 1'b0;
    load_valid = 1'b0;
    chk("clr prio count", count, 0);
    chk("clr done low", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty done", done, 1);
    chk("empty busy", busy, 0);
    chk("empty results", results, 0);
    for (int k = 0; k < 3; k++) begin
      chk("empty issue_valid", issue_valid, 0);
      chk("empty done held", done, 1);
      tick();
    end

    // Start coinciding with an accepted load includes that word
    load_valid = 1'b1;
    load_instr = {3'd1, 8'h23, 8'h14};
    start = 1'b1;
    tick();
    load_valid = 1'b0;
    start = 1'b0;
    chk("start+load count", count, 1);
    chk("start+load issue", {issue_valid, opcode}, {1'b1, 3'd1});
    prog_q = '{{3'd1, 8'h23, 8'h14}};
    run_prog(0);
    verify("start+load");

    // Reset while waiting on the third instruction
    prog_q = '{{3'd1, 8'h01, 8'h02}, {3'd6, 8'h10, 8'h00}, {3'd4, 8'h0F, 8'hF0}, {3'd2, 8'h09, 8'h03}};
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      result_valid = 1'b1;
      result_in = alu(prog_q[k][18:16], prog_q[k][15:8], prog_q[k][7:0]);
      tick();
      result_valid = 1'b0;
    end
    chk("third issue_valid", issue_valid, 1);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("third wait busy", busy, 1);
    chk("third wait results", results, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun rst busy", busy, 0);
    chk("midrun rst count", count, 0);
    chk("midrun rst issue_valid", issue_valid, 0);
    chk("midrun rst results", results, 0);
    chk("midrun rst fields", {opcode, operand_a, operand_b}, 0);
    tick();
    chk("midrun rst done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("after rst busy", busy, 0);
    chk("after rst load_ready", load_ready, 1);

    // Random programs
    for (int t = 0; t < 30; t++) begin
      int n;
      n = int'($urandom_range(1, 8));
      prog_q.delete();
      for (int i = 0; i < n; i++) prog_q.push_back({3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)});
      load_prog();
      chk("rand count", count, n);
      run_prog(1);
      verify("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
